// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI target transceiver, all CPOL/CPHA modes, MSB first.
// Optional: define SPI_SLAVE_UNDERRUN_EN to add the tx_underrun pulse output.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic              tx_underrun
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sq, cs_sq, mosi_sq;
  logic                   sclk_prev_q;
  state_t                 state_q, state_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d, tx_buf_q, tx_buf_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   miso_q, miso_d;
  logic                   consume;

  // Pins settle at their idle levels so no phantom edge appears after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sq     <= {SYNC_STAGES{mode[1]}};
      cs_sq       <= '1;
      mosi_sq     <= '0;
      sclk_prev_q <= mode[1];
    end else begin
      sclk_sq     <= {sclk_sq[SYNC_STAGES-2:0], sclk};
      cs_sq       <= {cs_sq[SYNC_STAGES-2:0], cs_n};
      mosi_sq     <= {mosi_sq[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sq[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s, rise, fall, lead, trail, sample_edge, shift_edge;
  logic [DATA_W-1:0] word_data;

  assign sclk_s      = sclk_sq[SYNC_STAGES-1];
  assign cs_s        = cs_sq[SYNC_STAGES-1];
  assign mosi_s      = mosi_sq[SYNC_STAGES-1];
  assign rise        = sclk_s & ~sclk_prev_q;
  assign fall        = ~sclk_s & sclk_prev_q;
  assign lead        = cpol_q ? fall : rise;
  assign trail       = cpol_q ? rise : fall;
  assign sample_edge = cpha_q ? trail : lead;
  assign shift_edge  = cpha_q ? lead : trail;
  assign word_data   = tx_ready_q ? '0 : tx_buf_q;

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    consume    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_s && en) begin
          state_d   = ACTIVE;
          cpol_d    = mode[1];
          cpha_d    = mode[0];
          bit_cnt_d = '0;
          consume   = 1'b1;
          // CPHA=1 waits for the first leading edge to present the MSB.
          if (mode[0]) begin
            tx_shift_d = word_data;
            miso_d     = 1'b0;
          end else begin
            tx_shift_d = word_data << 1;
            miso_d     = word_data[DATA_W-1];
          end
        end
      end
      ACTIVE: begin
        if (cs_s || !en) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end else begin
          if (shift_edge) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = tx_shift_q << 1;
          end
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              // Unshifted reload: the next shift edge presents the new MSB.
              tx_shift_d = word_data;
              consume    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (consume) tx_ready_d = 1'b1;
    if (tx_load && (tx_ready_q || consume)) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      miso_q     <= miso_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = (state_q == ACTIVE);
  assign miso     = miso_q;

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk) begin
    if (!rst_n) underrun_q <= 1'b0;
    else        underrun_q <= consume & tx_ready_q;
  end

  assign tx_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized bench for spi_slave with a word-level master and reference model.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       tx_underrun;
`endif

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .tx_underrun(tx_underrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: expected received words, single-entry tx buffer, underrun tally.
  logic [7:0] exp_rx_q[$];
  logic [7:0] last_rx = 8'h00;
  logic [7:0] buf_val = 8'h00;
  bit         buf_full = 1'b0;
  int         exp_underruns = 0;
  int         seen_underruns = 0;
  logic [7:0] mo_vals[4];
  logic [7:0] tx_vals[4];
  logic [7:0] mi_log[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          check("rx_word", 32'(rx_data), 32'(exp_rx_q[0]));
          last_rx = exp_rx_q.pop_front();
        end
      end else begin
        check("rx_hold", 32'(rx_data), 32'(last_rx));
      end
      check("oe_eq_busy", 32'(miso_oe), 32'(busy));
      if (!busy) check("miso_idle", 32'(miso), 32'd0);
`ifdef SPI_SLAVE_UNDERRUN_EN
      if (tx_underrun) seen_underruns++;
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    if (!buf_full) begin
      buf_val  = v;
      buf_full = 1'b1;
    end
    check("tx_ready_after_load", 32'(tx_ready), 32'(!buf_full));
  endtask

  // A word starts at selection and after every complete word: it takes the buffer or 0x00.
  task automatic model_start(output logic [7:0] cur);
    cur = buf_full ? buf_val : 8'h00;
    if (!buf_full) exp_underruns++;
    buf_full = 1'b0;
  endtask

  task automatic word(input logic [1:0] m, input logic [7:0] mo, input int nbits,
                      input int half, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = mo[7-i];
        cyc(half);
        sclk = ~m[1];
        mi[7-i] = miso;
        cyc(half);
        sclk = m[1];
      end else begin
        sclk = ~m[1];
        mosi = mo[7-i];
        cyc(half);
        sclk = m[1];
        mi[7-i] = miso;
        cyc(half);
      end
    end
  endtask

  task automatic txn(input logic [1:0] m, input int nw, input int abort_bits, input int half,
                     input int nload_before, input logic [3:0] load_mask, input logic en_v);
    logic [7:0] cur, mi;
    int nb;
    cur = 8'h00;
    en = en_v;
    mode = m;
    sclk = m[1];
    mosi = 1'b0;
    cyc(4);
    for (int k = 0; k < nload_before; k++) do_load(k == 0 ? tx_vals[0] : ~tx_vals[0]);
    cs_n = 1'b0;
    cyc(4);
    if (en_v) begin
      model_start(cur);
      check("tx_ready_sel", 32'(tx_ready), 32'd1);
      check("busy_sel", 32'(busy), 32'd1);
    end
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1 && abort_bits > 0) ? abort_bits : 8;
      if (load_mask[w]) do_load(tx_vals[w+1]);
      if (en_v && nb == 8) exp_rx_q.push_back(mo_vals[w]);
      word(m, mo_vals[w], nb, half, mi);
      mi_log[w] = mi;
      if (en_v && nb == 8) begin
        check("miso_word", 32'(mi), 32'(cur));
        model_start(cur);
      end
    end
    cyc(half);
    cs_n = 1'b1;
    cyc(8);
    check("busy_end", 32'(busy), 32'd0);
    check("miso_oe_end", 32'(miso_oe), 32'd0);
    check("rx_missing", 32'(exp_rx_q.size()), 32'd0);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("underrun_count", 32'(seen_underruns), 32'(exp_underruns));
`endif
    en = 1'b1;
  endtask

  initial begin
    logic [7:0] mi;
    cyc(3);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    mo_vals[0] = 8'hA5; tx_vals[0] = 8'h3C;
    txn(2'd0, 1, 0, 4, 1, 4'b0000, 1'b1);
    check("d_mode0_miso", 32'(mi_log[0]), 32'h3C);
    check("d_mode0_rx", 32'(rx_data), 32'hA5);

    for (int m = 1; m < 4; m++) begin
      mo_vals[0] = 8'h5A; tx_vals[0] = 8'hC3;
      txn(2'(m), 1, 0, 3 + m, 1, 4'b0000, 1'b1);
      check("d_modes_miso", 32'(mi_log[0]), 32'hC3);
      check("d_modes_rx", 32'(rx_data), 32'h5A);
    end

    mo_vals[0] = 8'h11; mo_vals[1] = 8'h22; tx_vals[0] = 8'hAA; tx_vals[1] = 8'hBB;
    txn(2'd0, 2, 0, 4, 1, 4'b0001, 1'b1);
    check("d_b2b_miso0", 32'(mi_log[0]), 32'hAA);
    check("d_b2b_miso1", 32'(mi_log[1]), 32'hBB);
    check("d_b2b_rx", 32'(rx_data), 32'h22);

    mo_vals[0] = 8'hF7;
    txn(2'd0, 1, 5, 4, 0, 4'b0000, 1'b1);
    check("d_abort_rx_hold", 32'(rx_data), 32'h22);
    mo_vals[0] = 8'h81;
    txn(2'd0, 1, 0, 4, 0, 4'b0000, 1'b1);
    check("d_after_abort_rx", 32'(rx_data), 32'h81);
    check("d_underrun_miso", 32'(mi_log[0]), 32'h00);

    mo_vals[0] = 8'h3E;
    txn(2'd1, 1, 0, 4, 0, 4'b0000, 1'b0);
    check("d_en_low_rx_hold", 32'(rx_data), 32'h81);

    mode = 2'd0; sclk = 1'b0;
    cyc(4);
    do_load(8'h77);
    cs_n = 1'b0;
    cyc(4);
    model_start(mi);
    word(2'd0, 8'hF0, 4, 4, mi);
    rst_n = 1'b0;
    cyc(2);
    check("mid_rst_rx_data", 32'(rx_data), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_miso", 32'(miso), 32'd0);
    check("mid_rst_miso_oe", 32'(miso_oe), 32'd0);
    cs_n = 1'b1;
    cyc(3);
    buf_full = 1'b0;
    last_rx = 8'h00;
    exp_rx_q.delete();
    rst_n = 1'b1;
    cyc(4);
    check("post_rst_tx_ready", 32'(tx_ready), 32'd1);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) begin
        mo_vals[k] = 8'($urandom);
        tx_vals[k] = 8'($urandom);
      end
      txn(2'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0,
          int'($urandom_range(3, 6)), int'($urandom_range(0, 2)),
          4'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (target) transceiver: the far end of the team's SPI master link.
- Oversamples externally driven SCLK/CS_N/MOSI on the system clock and supports all four CPOL/CPHA modes, MSB first.
- Delivers received bytes on a one-cycle valid strobe; returns bytes on MISO from a single-entry transmit buffer.
- Sits between SPI pins and a byte-wide register/FIFO client.

Parameters:
DATA_W, 8, bits per SPI word
SYNC_STAGES, 2, synchronizer flops on sclk, cs_n, mosi (min 2)

Ports:
clk  input  1  global clock
rst_n  input  1  reset, synchronous, active-low
en  input  1  block enable; low forces IDLE and ignores bus
mode  input  2  SPI mode: mode[1]=CPOL, mode[0]=CPHA; sampled at CS_N assertion
tx_data  input  DATA_W  byte to send on next word
tx_load  input  1  write tx_data into tx buffer; honoured only when tx_ready=1
tx_ready  output  1  tx buffer empty
rx_data  output  DATA_W  last complete received word
rx_valid  output  1  one-cycle strobe, rx_data updated
busy  output  1  high while in ACTIVE
sclk  input  1  SPI clock from master, asynchronous
cs_n  input  1  SPI chip select, active-low, asynchronous
mosi  input  1  SPI data in, asynchronous
miso  output  1  SPI data out
miso_oe  output  1  MISO tri-state enable, high while selected

Behaviour:
- Reset (rst_n low at posedge clk) gives: rx_data=0, rx_valid=0, tx_ready=1, busy=0, miso=0, miso_oe=0, state IDLE, synchronizers=idle levels (cs_n=1, sclk=CPOL, mosi=0).
- Inputs pass through SYNC_STAGES flops.
- Edge detect compares last sync stage with a one-cycle-delayed copy.
- Leading edge: rise if CPOL=0, fall if CPOL=1. Trailing edge is the opposite.
- CPHA=0: sample on leading edge, shift out on trailing edge. CPHA=1: shift out on leading edge, sample on trailing edge.
- Bus constraint: SCLK high and low each >= 3 clk periods; faster SCLK is unsupported and not checked.
- FSM IDLE -> ACTIVE: synced cs_n low and en=1. On entry:
  - latch mode; load tx shift register from the buffer (0 if buffer empty, i.e. underrun) and set tx_ready=1.
  - bit_cnt=0, miso_oe=1, busy=1.
  - CPHA=0: miso = shift MSB immediately.
  - CPHA=1: the first leading edge drives the MSB and is not a shift.
- ACTIVE, each sample edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++.
- When bit_cnt=DATA_W-1 at a sample edge:
  - rx_data <= full word; rx_valid=1 for exactly one cycle; bit_cnt wraps to 0.
  - Tx shift register reloads from the buffer (0 if empty), so back-to-back words need no CS_N toggle.
- ACTIVE, each shift-out edge: miso = next bit, MSB first.
- rx_valid latency: asserted SYNC_STAGES+1 clk edges after the final sample edge at the pin.
- ACTIVE -> IDLE when synced cs_n goes high or en goes low:
  - a partial word is discarded: no rx_valid, bit_cnt=0.
  - miso_oe=0, miso=0, busy=0. rx_data holds its value.
- tx_load:
  - tx_ready=1: buffer written and tx_ready=0 next cycle.
  - tx_ready=0: ignored, buffer unchanged.
  - Same cycle as a buffer consume: consume happens first and the load is accepted (tx_ready stays 0).
- SCLK edges while cs_n is high: ignored.
- mode changes while ACTIVE: take effect at the next selection only.

Optional Feature:
SPI_SLAVE_UNDERRUN_EN
- Defined: adds output port tx_underrun (1 bit, reset 0). It pulses for one cycle whenever a word starts (selection or word wrap) with the tx buffer empty; 0x00 is transmitted.
- Undefined: port absent; 0x00 is still sent silently on underrun.

Test Plan:
- Mode 0, SCLK=clk/8, tx_load 0x3C before CS_N, master sends 0xA5 -> rx_data=0xA5, one rx_valid pulse, MISO bits 0,0,1,1,1,1,0,0, tx_ready=1 after selection.
- Modes 1/2/3 each: master sends 0x5A, slave sends 0xC3 -> rx_data=0x5A and master receives 0xC3 in every mode.
- CS_N held low for two words 0x11, 0x22, with tx 0xAA then 0xBB loaded after the first tx_ready -> two rx_valid pulses (0x11, 0x22); MISO carries 0xAA then 0xBB.
- CS_N deasserted after 5 bits -> no rx_valid, rx_data unchanged, miso_oe=0, busy=0; the next full word 0x81 is received correctly.
- No tx_load before selection -> MISO all zero; with SPI_SLAVE_UNDERRUN_EN, one tx_underrun pulse per word.
- rst_n low mid-word, then released -> all outputs at reset values; no rx_valid for the interrupted word.
